// File: rtl/axis_batch_seq_if.sv
// Stream handshake bundle between the batch sequencer and the AXI-Stream ports.
// The master side is the sequencer: it accepts the input stream and drives the output stream.
interface axis_batch_seq_if;
    logic src_valid;
    logic src_last;
    logic src_ready;
    logic dst_valid;
    logic dst_last;
    logic dst_ready;

    modport master (
        input  src_valid,
        input  src_last,
        input  dst_ready,
        output src_ready,
        output dst_valid,
        output dst_last
    );

    modport slave (
        output src_valid,
        output src_last,
        output dst_ready,
        input  src_ready,
        input  dst_valid,
        input  dst_last
    );
endinterface

// File: rtl/axis_batch_seq.sv
// Batch sequencer: loads weights, biases and per-sample inputs from the stream,
// starts each sample's compute and streams the results out with TLAST framing.
module axis_batch_seq #(
    parameter  int F_NUM  = 16,
    parameter  int PRM_AW = 10,
    parameter  int SRC_AW = 12,
    parameter  int DST_AW = 12,
    parameter  int BN_W   = 8,
    localparam int CW     = (F_NUM > 1) ? $clog2(F_NUM) : 1
) (
    input  logic              AXIS_ACLK,
    input  logic              AXIS_ARESETN,
    input  logic              run,
    input  logic              wwrite,
    input  logic              bwrite,
    input  logic [BN_W-1:0]   bn,
    input  logic [SRC_AW-1:0] ss,
    input  logic [DST_AW-1:0] ds,
    input  logic [PRM_AW-1:0] ks,
    axis_batch_seq_if.master  axis,
    output logic [CW-1:0]     prm_v,
    output logic              prm_we,
    output logic [PRM_AW-1:0] prm_a,
    output logic              src_v,
    output logic [SRC_AW-1:0] src_a,
    output logic              dst_v,
    output logic [DST_AW-1:0] dst_a,
    output logic              s_init,
    input  logic              s_fin,
    output logic              busy,
    output logic              err_last
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WLD  = 3'd1,
        S_BLD  = 3'd2,
        S_SLD  = 3'd3,
        S_EXEC = 3'd4,
        S_DST  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        C_NONE = 2'd0,
        C_W    = 2'd1,
        C_B    = 2'd2,
        C_R    = 2'd3
    } cmd_t;

    localparam logic [CW-1:0] V_LAST = CW'(F_NUM - 1);

    state_t            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic [CW-1:0]     prm_v_q, prm_v_d;
    logic [PRM_AW-1:0] prm_a_q, prm_a_d;
    logic [SRC_AW-1:0] src_a_q, src_a_d;
    logic [DST_AW-1:0] dst_a_q, dst_a_d;
    logic [BN_W-1:0]   batch_q, batch_d;
    logic              src_ready_q, src_ready_d;
    logic              dst_valid_q, dst_valid_d;
    logic              dst_last_q, dst_last_d;
    logic              s_init_q, s_init_d;
    logic              busy_q, busy_d;
    logic              err_last_q, err_last_d;

    logic              cmd_bit_s;
    logic              src_hs_s;
    logic              dst_hs_s;
    logic              last_exp_s;
    logic [BN_W-1:0]   bn_eff_s;
    logic [PRM_AW-1:0] ks_last_s;
    logic [SRC_AW-1:0] ss_last_s;
    logic [DST_AW-1:0] ds_last_s;

    assign src_hs_s  = axis.src_valid & src_ready_q;
    assign dst_hs_s  = dst_valid_q & axis.dst_ready;
    assign bn_eff_s  = (bn == {BN_W{1'b0}}) ? BN_W'(1) : bn;
    assign ks_last_s = ks - PRM_AW'(1);
    assign ss_last_s = ss - SRC_AW'(1);
    assign ds_last_s = ds - DST_AW'(1);

    // Level of the command bit that launched the current operation.
    always_comb begin
        cmd_bit_s = 1'b0;
        case (cmd_q)
            C_W:     cmd_bit_s = wwrite;
            C_B:     cmd_bit_s = bwrite;
            C_R:     cmd_bit_s = run;
            default: cmd_bit_s = 1'b0;
        endcase
    end

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        prm_v_d    = prm_v_q;
        prm_a_d    = prm_a_q;
        src_a_d    = src_a_q;
        dst_a_d    = dst_a_q;
        batch_d    = batch_q;
        err_last_d = err_last_q;
        last_exp_s = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (wwrite) begin
                    state_d = S_WLD;
                    cmd_d   = C_W;
                end else if (bwrite) begin
                    state_d = S_BLD;
                    cmd_d   = C_B;
                end else if (run) begin
                    state_d = S_SLD;
                    cmd_d   = C_R;
                end else begin
                    state_d = S_IDLE;
                    cmd_d   = C_NONE;
                end
                if (state_d != S_IDLE) begin
                    err_last_d = 1'b0;
                    batch_d    = {BN_W{1'b0}};
                    prm_v_d    = {CW{1'b0}};
                    prm_a_d    = {PRM_AW{1'b0}};
                    src_a_d    = {SRC_AW{1'b0}};
                    dst_a_d    = {DST_AW{1'b0}};
                end else begin
                    err_last_d = err_last_q;
                end
            end
            S_DONE: begin
                if (!cmd_bit_s) begin
                    state_d = S_IDLE;
                    cmd_d   = C_NONE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                // Dropping the command aborts everything except the sticky error.
                if (!cmd_bit_s) begin
                    state_d = S_IDLE;
                    cmd_d   = C_NONE;
                    prm_v_d = {CW{1'b0}};
                    prm_a_d = {PRM_AW{1'b0}};
                    src_a_d = {SRC_AW{1'b0}};
                    dst_a_d = {DST_AW{1'b0}};
                    batch_d = {BN_W{1'b0}};
                end else begin
                    case (state_q)
                        S_WLD: begin
                            last_exp_s = (prm_v_q == V_LAST) && (prm_a_q == ks_last_s);
                            if (src_hs_s && (prm_a_q == ks_last_s)) begin
                                prm_a_d = {PRM_AW{1'b0}};
                                if (prm_v_q == V_LAST) begin
                                    prm_v_d = {CW{1'b0}};
                                    state_d = S_DONE;
                                end else begin
                                    prm_v_d = prm_v_q + CW'(1);
                                end
                            end else if (src_hs_s) begin
                                prm_a_d = prm_a_q + PRM_AW'(1);
                            end else begin
                                prm_a_d = prm_a_q;
                            end
                        end
                        S_BLD: begin
                            last_exp_s = (prm_v_q == V_LAST);
                            prm_a_d    = {PRM_AW{1'b0}};
                            if (src_hs_s && (prm_v_q == V_LAST)) begin
                                prm_v_d = {CW{1'b0}};
                                state_d = S_DONE;
                            end else if (src_hs_s) begin
                                prm_v_d = prm_v_q + CW'(1);
                            end else begin
                                prm_v_d = prm_v_q;
                            end
                        end
                        S_SLD: begin
                            last_exp_s = (src_a_q == ss_last_s);
                            if (src_hs_s && (src_a_q == ss_last_s)) begin
                                src_a_d = {SRC_AW{1'b0}};
                                state_d = S_EXEC;
                            end else if (src_hs_s) begin
                                src_a_d = src_a_q + SRC_AW'(1);
                            end else begin
                                src_a_d = src_a_q;
                            end
                        end
                        S_EXEC: begin
                            if (s_fin) begin
                                state_d = S_DST;
                                dst_a_d = {DST_AW{1'b0}};
                            end else begin
                                state_d = S_EXEC;
                            end
                        end
                        S_DST: begin
                            if (dst_hs_s && (dst_a_q == ds_last_s)) begin
                                dst_a_d = {DST_AW{1'b0}};
                                batch_d = batch_q + BN_W'(1);
                                if (batch_d == bn_eff_s) begin
                                    state_d = S_DONE;
                                end else begin
                                    state_d = S_SLD;
                                end
                            end else if (dst_hs_s) begin
                                dst_a_d = dst_a_q + DST_AW'(1);
                            end else begin
                                dst_a_d = dst_a_q;
                            end
                        end
                        default: begin
                            state_d = S_IDLE;
                            cmd_d   = C_NONE;
                        end
                    endcase
                    if (src_hs_s && (axis.src_last != last_exp_s)) begin
                        err_last_d = 1'b1;
                    end else begin
                        err_last_d = err_last_q;
                    end
                end
            end
        endcase

        src_ready_d = (state_d == S_WLD) || (state_d == S_BLD) || (state_d == S_SLD);
        dst_valid_d = (state_d == S_DST);
        dst_last_d  = dst_valid_d && (dst_a_d == ds_last_s) &&
                      (batch_d == (bn_eff_s - BN_W'(1)));
        s_init_d    = (state_d == S_EXEC) && (state_q != S_EXEC);
        busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state_q     <= S_IDLE;
            cmd_q       <= C_NONE;
            prm_v_q     <= {CW{1'b0}};
            prm_a_q     <= {PRM_AW{1'b0}};
            src_a_q     <= {SRC_AW{1'b0}};
            dst_a_q     <= {DST_AW{1'b0}};
            batch_q     <= {BN_W{1'b0}};
            src_ready_q <= 1'b0;
            dst_valid_q <= 1'b0;
            dst_last_q  <= 1'b0;
            s_init_q    <= 1'b0;
            busy_q      <= 1'b0;
            err_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            prm_v_q     <= prm_v_d;
            prm_a_q     <= prm_a_d;
            src_a_q     <= src_a_d;
            dst_a_q     <= dst_a_d;
            batch_q     <= batch_d;
            src_ready_q <= src_ready_d;
            dst_valid_q <= dst_valid_d;
            dst_last_q  <= dst_last_d;
            s_init_q    <= s_init_d;
            busy_q      <= busy_d;
            err_last_q  <= err_last_d;
        end
    end

    assign axis.src_ready = src_ready_q;
    assign axis.dst_valid = dst_valid_q;
    assign axis.dst_last  = dst_last_q;
    assign prm_v    = prm_v_q;
    assign prm_a    = prm_a_q;
    assign src_a    = src_a_q;
    assign dst_a    = dst_a_q;
    assign s_init   = s_init_q;
    assign busy     = busy_q;
    assign err_last = err_last_q;
    // Buffer strobes follow the live handshake so a write is never delayed past its data.
    assign prm_we   = src_hs_s & ((state_q == S_WLD) || (state_q == S_BLD));
    assign src_v    = src_hs_s & (state_q == S_SLD);
    assign dst_v    = dst_hs_s;

endmodule
